hex_keypad_scanner: RTL and testbench
=====================================

// Module: hex_keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix hex keypad (active-low rows driven, active-low columns sensed).
//  Debounces presses and decodes each one to a 4-bit hex code.
//  Shifts each accepted digit into a 4*DIGITS-bit value register.
//  Input-side counterpart of the multiplexed 7-seg driver: value can feed that driver's values input directly.
// PARAMETERS
//  SCAN_TICKS      100_000  clk cycles per row slot (1 ms @ 100 MHz); must be >= 4
//  DEBOUNCE_SCANS  4        consecutive matching samples needed to accept a press or a release; >= 1
//  DIGITS          4        hex digits held in value
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  reset      in   1          asynchronous, active-high reset
//  row_n      out  4          row drive, exactly one bit low at any time
//  col_n      in   4          column sense, active-low, async (pulled up off-chip)
//  clr        in   1          synchronous clear of value
//  key_code   out  4          hex code of last accepted key
//  key_pulse  out  1          one-cycle strobe on accepted press
//  key_held   out  1          high while accepted key is still down
//  value      out  4*DIGITS   shift register of entered digits, newest digit in [3:0]
// BEHAVIOUR
//  Reset values: row_n=4'b1110, key_code=0, key_pulse=0, key_held=0, value=0.
//  Reset values (internal): FSM=SCAN, all counters 0.
//  col_n passes through a 2-FF synchronizer. Samples use the synchronized value only.
//  Tick: slot counter counts 0..SCAN_TICKS-1 and wraps.
//  Sample point: the cycle where count==SCAN_TICKS-1. Col is sampled there, giving time to settle after a row change.
//  Valid key: exactly one col bit low in the sample. Zero bits low = idle. Two or more low = ghost; treated as idle.
//  FSM SCAN:
//   - Idle sample: next row, row_n rotates 1110->1101->1011->0111->1110.
//   - Valid sample: latch row/col index, row_n frozen, match count=1, go DEBOUNCE.
//  FSM DEBOUNCE:
//   - Same single col at the sample: count++.
//   - count reaches DEBOUNCE_SCANS: go PRESSED. In the same cycle:
//     - key_code <= map(row, col)
//     - key_pulse <= 1
//     - value <= {value[4*DIGITS-5:0], code}
//   - Any other sample: back to SCAN, next row.
//   - DEBOUNCE_SCANS=1 accepts on the first sample, going SCAN->PRESSED directly.
//  FSM PRESSED: key_held=1, row frozen.
//   - Idle sample: release count++. Any low bit resets release count to 0.
//   - Release count reaches DEBOUNCE_SCANS: go SCAN, key_held<=0, advance row.
//   - A second key held with the first does not generate a press.
//  Keymap (row,col):
//   - row0 = 1 2 3 A
//   - row1 = 4 5 6 B
//   - row2 = 7 8 9 C
//   - row3 = 0 F E D
//  Latency: key_pulse is asserted 1 cycle after the DEBOUNCE_SCANS-th matching sample.
//  Key must be stable through the 2-FF stage before the first sample.
//  key_pulse is never asserted on two consecutive cycles. Max one pulse per press-release cycle.
//  clr: value<=0 next cycle.
//   - clr coincident with acceptance: clr wins for value.
//   - key_pulse and key_code still update on that cycle.
//  value overflow: the oldest digit is shifted out silently.
//  Async reset mid-debounce or mid-press: returns to reset values immediately. No pulse is emitted.
// STRUCTURE
//  Package hex_keypad_pkg holds:
//   - typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} kp_state_t
//   - 16-entry keymap constant KEYMAP[row*4+col]
//   - function col_onehot_idx() returning valid flag plus col index
//  Sub-module keypad_slot_timer (parameter SCAN_TICKS): free-running counter, output sample_tick.
//  FSM, synchronizer, row rotator and value register live in the top.
// TESTING (SCAN_TICKS=4, DEBOUNCE_SCANS=2, DIGITS=4)
//  1. Idle cols 4'hF after reset:
//     - row_n cycles 1110,1101,1011,0111 every 4 clk
//     - key_pulse never asserted, value=0
//  2. Hold row1/col2 low (key 6) for 20 cycles:
//     - exactly one key_pulse with key_code=6, value=16'h0006
//     - key_held=1 until 2 idle samples after release
//  3. Keys 1,A,F,0 pressed and released in turn, then key 7:
//     - after four presses value=16'h1AF0
//     - fifth press gives 16'hAF07
//  4. Bounce: col low for one sample, high the next, low again:
//     - no pulse, FSM returns to SCAN
//     - stable 2 samples later then yields one pulse
//  5. Ghost: two col bits low on row0 → no pulse, scanning continues.
//     Hold key 5, then press key 9 too → no second pulse.
//  6. reset asserted in DEBOUNCE → all outputs at reset values on the same edge.
//     clr with acceptance → value=0, key_pulse=1.

Source files
------------

// File: rtl/hex_keypad_pkg.sv
// Shared types, keymap and column decode for the hex keypad scanner.
// Imported by the scanner top and its slot timer.
package hex_keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED
  } kp_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } col_sel_t;

  // Indexed by {row, col}
  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  // Exactly one low column is a key; none or several read as idle.
  function automatic col_sel_t col_onehot_idx(
    input logic [3:0] col_n
  );
    col_sel_t r;
    r = '0;
    case (col_n)
      4'b1110: r = '{valid: 1'b1, idx: 2'd0};
      4'b1101: r = '{valid: 1'b1, idx: 2'd1};
      4'b1011: r = '{valid: 1'b1, idx: 2'd2};
      4'b0111: r = '{valid: 1'b1, idx: 2'd3};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_slot_timer.sv
// Free-running row slot counter for the keypad scanner.
// sample_tick marks the last cycle of each slot.
module keypad_slot_timer
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_TICKS = 100_000
) (
  input  logic clk,
  input  logic reset,
  output logic sample_tick
);

  localparam int CW = $clog2(SCAN_TICKS);

  logic [CW-1:0] cnt;

  assign sample_tick = (cnt == CW'(SCAN_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else if (sample_tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: row rotation, debounce FSM and digit shift register.
// value is laid out to feed a multiplexed 7-seg driver directly.
module hex_keypad_scanner
  import hex_keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DIGITS         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [3:0]            row_n,
  input  logic [3:0]            col_n,
  input  logic                  clr,
  output logic [3:0]            key_code,
  output logic                  key_pulse,
  output logic                  key_held,
  output logic [4*DIGITS-1:0]   value
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int VW = 4 * DIGITS;

  logic [3:0]    col_s1, col_s2;
  logic          tick;
  kp_state_t     state, state_n;
  logic [1:0]    ridx, ridx_n;
  logic [1:0]    kcol, kcol_n;
  logic [CW-1:0] mcnt, mcnt_n;
  logic [CW-1:0] rcnt, rcnt_n;
  logic [3:0]    code_n;
  logic          pulse_n, held_n, acc;
  logic [VW-1:0] value_n;
  col_sel_t      cs;
  logic          idle;

  keypad_slot_timer #(
    .SCAN_TICKS(SCAN_TICKS)
  ) u_timer (
    .clk(clk),
    .reset(reset),
    .sample_tick(tick)
  );

  assign row_n = ~(4'b0001 << ridx);
  assign cs    = col_onehot_idx(col_s2);
  assign idle  = (col_s2 == 4'hF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_s1    <= 4'hF;
      col_s2    <= 4'hF;
      state     <= SCAN;
      ridx      <= '0;
      kcol      <= '0;
      mcnt      <= '0;
      rcnt      <= '0;
      key_code  <= '0;
      key_pulse <= 1'b0;
      key_held  <= 1'b0;
      value     <= '0;
    end else begin
      col_s1    <= col_n;
      col_s2    <= col_s1;
      state     <= state_n;
      ridx      <= ridx_n;
      kcol      <= kcol_n;
      mcnt      <= mcnt_n;
      rcnt      <= rcnt_n;
      key_code  <= code_n;
      key_pulse <= pulse_n;
      key_held  <= held_n;
      value     <= value_n;
    end
  end

  always_comb begin
    state_n = state;
    ridx_n  = ridx;
    kcol_n  = kcol;
    mcnt_n  = mcnt;
    rcnt_n  = rcnt;
    code_n  = key_code;
    pulse_n = 1'b0;
    held_n  = key_held;
    value_n = value;
    acc     = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (cs.valid) begin
            kcol_n = cs.idx;
            mcnt_n = CW'(1);
            if (DEBOUNCE_SCANS == 1) acc = 1'b1;
            else state_n = DEBOUNCE;
          end else begin
            ridx_n = ridx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cs.valid && cs.idx == kcol) begin
            mcnt_n = mcnt + CW'(1);
            if (mcnt_n == CW'(DEBOUNCE_SCANS)) acc = 1'b1;
          end else begin
            state_n = SCAN;
            ridx_n  = ridx + 2'd1;
            mcnt_n  = '0;
          end
        end
        PRESSED: begin
          if (idle) begin
            rcnt_n = rcnt + CW'(1);
            if (rcnt_n == CW'(DEBOUNCE_SCANS)) begin
              state_n = SCAN;
              held_n  = 1'b0;
              ridx_n  = ridx + 2'd1;
              rcnt_n  = '0;
            end
          end else begin
            rcnt_n = '0;
          end
        end
        default: state_n = SCAN;
      endcase
    end
    if (acc) begin
      state_n      = PRESSED;
      code_n       = KEYMAP[{ridx, kcol_n}];
      pulse_n      = 1'b1;
      held_n       = 1'b1;
      mcnt_n       = '0;
      rcnt_n       = '0;
      value_n      = value << 4;
      value_n[3:0] = code_n;
    end
    // Clear beats a same-cycle acceptance for value only
    if (clr) value_n = '0;
  end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner with a modelled 4x4 key matrix.
// Each press pushes its expected code/value; the pulse monitor pops them.
module tb_hex_keypad_scanner;

  localparam int ST = 4;
  localparam int DS = 2;
  localparam int DG = 4;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_pulse, key_held;
  logic [15:0] value;
  logic [15:0] keys = '0;
  logic [15:0] exp_val = '0;
  logic        prev_pulse = 1'b0;
  logic [3:0]  rowv;
  exp_t        sbq[$];
  int          nchk = 0;
  int          nerr = 0;

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  hex_keypad_scanner #(
    .SCAN_TICKS(ST),
    .DEBOUNCE_SCANS(DS),
    .DIGITS(DG)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .clr(clr),
    .key_code(key_code),
    .key_pulse(key_pulse),
    .key_held(key_held),
    .value(value)
  );

  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (key_pulse) begin
        check("pulse_gap", {31'd0, prev_pulse}, 0);
        check("pulse_expected", {31'd0, sbq.size() > 0}, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("key_code", {28'd0, key_code}, {28'd0, e.code});
          check("value", {16'd0, value}, {16'd0, e.val});
        end
      end
      prev_pulse = key_pulse;
    end
  end

  task automatic wait_held(input logic v, input string tag, input int maxc);
    int n = 0;
    while (key_held !== v && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, key_held}, {31'd0, v});
  endtask

  task automatic push_exp(input logic [3:0] code);
    exp_t e;
    exp_val = {exp_val[11:0], code};
    e.code = code;
    e.val = exp_val;
    sbq.push_back(e);
  endtask

  task automatic press_key(input int r, input int c);
    push_exp(kmap[r*4+c]);
    keys[r*4+c] = 1'b1;
    wait_held(1'b1, "press_held", 80);
  endtask

  task automatic release_all();
    keys = '0;
    wait_held(1'b0, "release_held", 40);
  endtask

  // Returns on the first negedge after row_n switches to tgt
  task automatic wait_row(input logic [3:0] tgt);
    int n = 0;
    while (row_n == tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (row_n != tgt && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("row_seek", {28'd0, row_n}, {28'd0, tgt});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state",
          {6'd0, row_n, key_code, key_pulse, key_held, value},
          {6'd0, 4'b1110, 4'h0, 1'b0, 1'b0, 16'h0});
    reset = 1'b0;

    // Idle rotation
    @(negedge clk);
    rowv = row_n;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      check("row_rot", {28'd0, row_n}, {28'd0, rowv[2:0], rowv[3]});
      rowv = row_n;
    end
    check("idle_value", {16'd0, value}, 0);

    // Key 6 held, then release timing
    press_key(1, 2);
    repeat (10) @(negedge clk);
    check("held_6", {31'd0, key_held}, 1);
    keys = '0;
    repeat (4) @(negedge clk);
    check("held_after_rel", {31'd0, key_held}, 1);
    wait_held(1'b0, "release_6", 20);
    check("value_6", {16'd0, value}, 32'h0006);

    // Digit sequence
    press_key(0, 0); release_all();
    press_key(0, 3); release_all();
    press_key(3, 1); release_all();
    press_key(3, 0); release_all();
    check("value_4", {16'd0, value}, 32'h1AF0);
    press_key(2, 0); release_all();
    check("value_5", {16'd0, value}, 32'hAF07);

    // Bounce on key 8
    wait_row(4'b1011);
    keys[9] = 1'b1;
    repeat (4) @(negedge clk);
    check("bounce_frozen", {28'd0, row_n}, {28'd0, 4'b1011});
    keys = '0;
    repeat (4) @(negedge clk);
    check("bounce_rescan", {28'd0, row_n}, {28'd0, 4'b0111});
    press_key(2, 1); release_all();
    check("value_8", {16'd0, value}, 32'hF078);

    // Ghost on row0
    wait_row(4'b1110);
    keys[0] = 1'b1;
    keys[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("ghost_scan", {28'd0, row_n}, {28'd0, 4'b1101});
    repeat (30) @(negedge clk);
    check("ghost_held", {31'd0, key_held}, 0);
    keys = '0;
    repeat (8) @(negedge clk);

    // Key 5 held, key 9 joins
    press_key(1, 1);
    keys[10] = 1'b1;
    repeat (30) @(negedge clk);
    check("two_key_held", {31'd0, key_held}, 1);
    check("two_key_code", {28'd0, key_code}, 32'h5);
    release_all();
    check("value_5b", {16'd0, value}, 32'h0785);

    // Async reset during debounce of key C
    wait_row(4'b1011);
    keys[11] = 1'b1;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("reset_mid",
          {6'd0, row_n, key_code, key_pulse, key_held, value},
          {6'd0, 4'b1110, 4'h0, 1'b0, 1'b0, 16'h0});
    keys = '0;
    exp_val = '0;
    prev_pulse = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Clear coinciding with acceptance of key D
    begin
      exp_t e;
      e.code = 4'hD;
      e.val = 16'h0;
      sbq.push_back(e);
      exp_val = '0;
    end
    wait_row(4'b0111);
    keys[15] = 1'b1;
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_acc_pulse", {31'd0, key_pulse}, 1);
    release_all();

    press_key(0, 2); release_all();
    check("value_3", {16'd0, value}, 32'h0003);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_plain", {16'd0, value}, 0);

    repeat (4) @(negedge clk);
    check("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
